bp_be_scoreboard_detector: RTL and testbench
============================================

Name: bp_be_scoreboard_detector

Overview:
- Next-generation backend hazard detector. Owns its own shadow of the in-flight pipeline and a register scoreboard, so it no longer depends on a fixed 3-stage dependency vector.
- Generalised in pipeline depth and source-operand count. Adds tracking of out-of-order long-latency writebacks (div, fdiv/fsqrt), a serialise/drain FSM, and stall-cause counters.
- Sits between the issue stage and the calculator. Drives chk_dispatch_v_o.

Parameters:
- pipe_depth_p, 5, number of tracked post-dispatch stages (stage 0 = EX1)
- num_src_p, 3, source operands per instruction
- reg_addr_width_p, 5, register address width; one scoreboard per file holds 2^reg_addr_width_p entries
- cnt_width_p, 32, width of each stall counter
- stage_width_p, $clog2(pipe_depth_p+1), width of the forward-stage field (local)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- isd_v_i  in  1  valid instruction in issue
- isd_src_v_i  in  num_src_p  per-source read enable
- isd_src_fp_i  in  num_src_p  per-source file select (1 = FP)
- isd_src_addr_i  in  num_src_p*reg_addr_width_p  source addresses
- isd_rd_v_i  in  1  writes a destination
- isd_rd_fp_i  in  1  destination file
- isd_rd_addr_i  in  reg_addr_width_p  destination address
- isd_fwd_stage_i  in  stage_width_p  first stage index from which the result is forwardable
- isd_long_i  in  1  long-latency op; completes via the late writeback port
- isd_mem_i  in  1  memory op
- isd_fence_i  in  1  fence
- isd_serial_i  in  1  serialising op (CSR, eret, etc.)
- flush_i  in  1  pipeline flush
- late_wb_v_i  in  1  long-latency writeback
- late_wb_fp_i  in  1  writeback file
- late_wb_addr_i  in  reg_addr_width_p  writeback address
- credits_full_i, credits_empty_i, mmu_cmd_ready_i, fe_cmd_ready_i  in  1 each  memory/FE status
- chk_dispatch_v_o  out  1  issue may dispatch
- idle_o  out  1  pipeline shadow and both scoreboards empty, FSM IDLE
- data_stall_cnt_o, ctrl_stall_cnt_o, struct_stall_cnt_o  out  cnt_width_p each  saturating stall-cycle counters

Behaviour:
- Dispatch event: dispatch = isd_v_i & chk_dispatch_v_o & ~flush_i.
- Shadow pipe: pipe_depth_p entries {v, rd_v, fp, addr, fwd_stage}.
  - Shifts every cycle; there is no back-pressure after dispatch.
  - Stage 0 loads the issue entry with v = dispatch.
  - For long ops, stage 0 loads rd_v = 0; the scoreboard tracks the destination instead.
  - flush_i clears v in all stages at the clock edge; the issue entry is not inserted.
- Data hazard for a source: src_v & ~(int file & addr==0) & any of:
  - some stage i with v & rd_v, matching fp/addr, and i+1 < fwd_stage (result not forwardable by the next cycle);
  - scoreboard bit set for the source's file/addr;
  - WAW: isd_rd_v_i and the scoreboard bit set for the issuing destination.
- Scoreboard: int and fp bit vectors.
  - Set on dispatch & isd_long_i & isd_rd_v_i.
  - Cleared on late_wb_v_i.
  - Same-cycle set and clear of the same bit: the set wins.
  - A write to int x0 is never set.
  - Not cleared by flush: long ops in flight still write back.
- Late-writeback bypass: a late_wb_v_i match in the current cycle does not clear the hazard that cycle; the source is eligible the next cycle.
- Serial FSM, states IDLE and DRAIN:
  - IDLE to DRAIN on dispatch & (isd_serial_i | isd_fence_i).
  - In DRAIN, chk_dispatch_v_o = 0.
  - DRAIN to IDLE when no shadow stage is valid, both scoreboards are zero, and credits_empty_i = 1. Dispatch is allowed from the following cycle.
  - flush_i in DRAIN does not exit DRAIN; the drain condition still applies.
- Control hazard: FSM in DRAIN | (isd_fence_i & (~credits_empty_i | any valid stage)) | (isd_mem_i & credits_full_i).
- Struct hazard: ~fe_cmd_ready_i | (isd_mem_i & ~mmu_cmd_ready_i).
- chk_dispatch_v_o = ~(data | control | struct).
  - Combinational from the inputs and state.
  - Independent of isd_v_i.
- Counters: each increments per cycle with isd_v_i & its hazard. Multiple causes in one cycle increment all matching counters. Each saturates at all-ones.
- Reset (reset_i low, asynchronous):
  - shadow v = 0, scoreboards = 0, FSM = IDLE, counters = 0.
  - Outputs during reset: chk_dispatch_v_o = 1 (given fe_cmd_ready_i = 1), idle_o = 1, counters = 0.
  - Reset mid-DRAIN returns the FSM to IDLE.

Decomposition:
- bp_be_pkg gains the bp_be_shadow_entry_s typedef and the FSM enum e_det_idle / e_det_drain.
- One sub-module: bp_be_scoreboard (parametrised by reg_addr_width_p; set/clear ports, bit-vector output). Instantiated once per register file.
- Counters are inline.

Test Plan:
- RAW on a 3-cycle-forward op: dispatch rd=x5 with fwd_stage=3, then issue src x5 -> chk_dispatch_v_o low for 2 cycles, high on cycle 3; data_stall_cnt_o = 2.
- x0 and file separation: rd=x0 int in pipe, issue src x0; rd=f3 in pipe, issue int src x3 -> no stall in either case.
- Long op: dispatch div rd=x7, late_wb at cycle 20 -> a src x7 issue stalls cycles 1–20 and dispatches at 21. A late_wb same-cycle as a new set to x7 leaves the bit set.
- Serialise: dispatch CSR with 2 stages valid and credits_empty_i=0 until cycle 6 -> FSM DRAIN; dispatch is blocked until pipe empty; returns to IDLE at cycle 7; ctrl_stall_cnt_o counts the blocked cycles.
- Flush: 4 valid stages with a pending RAW, assert flush_i -> next cycle no data hazard, and the scoreboard is unchanged.
- Async reset mid-DRAIN with counters nonzero -> immediate idle_o=1 and counters=0. A counter preloaded near max saturates at all-ones.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared backend types for the hazard detector.
// Shadow-pipe entry layout and serial FSM states.
package bp_be_pkg;

  localparam int det_addr_max_gp  = 8;
  localparam int det_stage_max_gp = 8;

  typedef logic [det_addr_max_gp-1:0]  det_addr_t;
  typedef logic [det_stage_max_gp-1:0] det_stage_t;

  typedef struct packed {
    logic       v;
    logic       rd_v;
    logic       fp;
    det_addr_t  addr;
    det_stage_t fwd_stage;
  } bp_be_shadow_entry_s;

  typedef enum logic {
    e_det_idle  = 1'b0,
    e_det_drain = 1'b1
  } bp_be_det_state_e;

  // Integer x0 is hardwired and never creates a dependency.
  function automatic logic is_int_x0(
    input logic      fp,
    input det_addr_t addr
  );
    return !fp && (addr == '0);
  endfunction

endpackage

// File: rtl/bp_be_scoreboard.sv
// Busy-bit scoreboard for one register file.
// Tracks destinations of long-latency ops until writeback.
module bp_be_scoreboard #(
  parameter  int reg_addr_width_p = 5,
  localparam int entries_lp = 1 << reg_addr_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        set_v_i,
  input  logic [reg_addr_width_p-1:0] set_addr_i,
  input  logic                        clr_v_i,
  input  logic [reg_addr_width_p-1:0] clr_addr_i,
  output logic [entries_lp-1:0]       busy_o
);

  logic [entries_lp-1:0] busy_r;
  logic [entries_lp-1:0] set_mask;
  logic [entries_lp-1:0] clr_mask;

  // One-hot decode of the set and clear requests.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    set_mask[set_addr_i] = set_v_i;
    clr_mask[clr_addr_i] = clr_v_i;
  end

  // Set is applied after clear so a same-cycle set wins.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_mask) | set_mask;
    end
  end

  assign busy_o = busy_r;

endmodule

// File: rtl/bp_be_scoreboard_detector.sv
// Backend hazard detector: shadow pipe, scoreboards,
// serialise/drain FSM and saturating stall counters.
module bp_be_scoreboard_detector
  import bp_be_pkg::*;
#(
  parameter  int pipe_depth_p     = 5,
  parameter  int num_src_p        = 3,
  parameter  int reg_addr_width_p = 5,
  parameter  int cnt_width_p      = 32,
  localparam int stage_width_p    = $clog2(pipe_depth_p+1),
  localparam int entries_lp       = 1 << reg_addr_width_p
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          isd_v_i,
  input  logic [num_src_p-1:0]          isd_src_v_i,
  input  logic [num_src_p-1:0]          isd_src_fp_i,
  input  logic [num_src_p*reg_addr_width_p-1:0]
                                        isd_src_addr_i,
  input  logic                          isd_rd_v_i,
  input  logic                          isd_rd_fp_i,
  input  logic [reg_addr_width_p-1:0]   isd_rd_addr_i,
  input  logic [stage_width_p-1:0]      isd_fwd_stage_i,
  input  logic                          isd_long_i,
  input  logic                          isd_mem_i,
  input  logic                          isd_fence_i,
  input  logic                          isd_serial_i,
  input  logic                          flush_i,
  input  logic                          late_wb_v_i,
  input  logic                          late_wb_fp_i,
  input  logic [reg_addr_width_p-1:0]   late_wb_addr_i,
  input  logic                          credits_full_i,
  input  logic                          credits_empty_i,
  input  logic                          mmu_cmd_ready_i,
  input  logic                          fe_cmd_ready_i,
  output logic                          chk_dispatch_v_o,
  output logic                          idle_o,
  output logic [cnt_width_p-1:0]        data_stall_cnt_o,
  output logic [cnt_width_p-1:0]        ctrl_stall_cnt_o,
  output logic [cnt_width_p-1:0]        struct_stall_cnt_o
);

  bp_be_shadow_entry_s shadow_r [pipe_depth_p];
  bp_be_shadow_entry_s issue_entry;
  bp_be_det_state_e    state_r;

  logic [entries_lp-1:0] int_busy;
  logic [entries_lp-1:0] fp_busy;
  logic [num_src_p-1:0]  src_haz;

  logic dispatch;
  logic any_v;
  logic sb_empty;
  logic drain;
  logic drain_done;
  logic waw_haz;
  logic data_haz;
  logic ctrl_haz;
  logic struct_haz;

  logic [cnt_width_p-1:0] data_cnt_r;
  logic [cnt_width_p-1:0] ctrl_cnt_r;
  logic [cnt_width_p-1:0] struct_cnt_r;

  localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);

  assign dispatch = isd_v_i & chk_dispatch_v_o & ~flush_i;

  // Entry captured into EX1; long ops hand their rd to the scoreboard.
  always_comb begin
    issue_entry           = '0;
    issue_entry.v         = dispatch;
    issue_entry.rd_v      = isd_rd_v_i & ~isd_long_i;
    issue_entry.fp        = isd_rd_fp_i;
    issue_entry.addr      = det_addr_t'(isd_rd_addr_i);
    issue_entry.fwd_stage = det_stage_t'(isd_fwd_stage_i);
  end

  // Shadow pipe advances every cycle; flush kills every stage.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < pipe_depth_p; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      shadow_r[0] <= issue_entry;
      for (int i = 1; i < pipe_depth_p; i++) begin
        shadow_r[i] <= shadow_r[i-1];
      end
      if (flush_i) begin
        for (int i = 0; i < pipe_depth_p; i++) begin
          shadow_r[i].v <= 1'b0;
        end
      end
    end
  end

  // Any live instruction still in the shadow pipe.
  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < pipe_depth_p; i++) begin
      any_v = any_v | shadow_r[i].v;
    end
  end

  bp_be_scoreboard #(
    .reg_addr_width_p(reg_addr_width_p)
  ) int_sb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_v_i   (dispatch & isd_long_i & isd_rd_v_i
                & ~isd_rd_fp_i & (isd_rd_addr_i != '0)),
    .set_addr_i(isd_rd_addr_i),
    .clr_v_i   (late_wb_v_i & ~late_wb_fp_i),
    .clr_addr_i(late_wb_addr_i),
    .busy_o    (int_busy)
  );

  bp_be_scoreboard #(
    .reg_addr_width_p(reg_addr_width_p)
  ) fp_sb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_v_i   (dispatch & isd_long_i & isd_rd_v_i
                & isd_rd_fp_i),
    .set_addr_i(isd_rd_addr_i),
    .clr_v_i   (late_wb_v_i & late_wb_fp_i),
    .clr_addr_i(late_wb_addr_i),
    .busy_o    (fp_busy)
  );

  assign sb_empty = ~|int_busy & ~|fp_busy;

  for (genvar s = 0; s < num_src_p; s++) begin : g_src
    logic [reg_addr_width_p-1:0] addr;
    logic                        fp;
    logic                        pipe_hit;
    logic                        sb_hit;

    assign addr =
      isd_src_addr_i[s*reg_addr_width_p +: reg_addr_width_p];
    assign fp = isd_src_fp_i[s];

    // Producer in flight whose result is not ready next cycle.
    always_comb begin
      pipe_hit = 1'b0;
      for (int i = 0; i < pipe_depth_p; i++) begin
        if (shadow_r[i].v && shadow_r[i].rd_v
            && (shadow_r[i].fp == fp)
            && (shadow_r[i].addr == det_addr_t'(addr))
            && ((i + 1) < int'(shadow_r[i].fwd_stage))) begin
          pipe_hit = 1'b1;
        end
      end
    end

    // Registered busy bit: a same-cycle writeback is not bypassed.
    assign sb_hit = fp ? fp_busy[addr] : int_busy[addr];

    assign src_haz[s] = isd_src_v_i[s]
      & ~is_int_x0(fp, det_addr_t'(addr))
      & (pipe_hit | sb_hit);
  end

  assign waw_haz = isd_rd_v_i
    & (isd_rd_fp_i ? fp_busy[isd_rd_addr_i]
                   : int_busy[isd_rd_addr_i]);

  assign data_haz   = |src_haz | waw_haz;
  assign drain      = (state_r == e_det_drain);
  assign drain_done = ~any_v & sb_empty & credits_empty_i;

  assign ctrl_haz = drain
    | (isd_fence_i & (~credits_empty_i | any_v))
    | (isd_mem_i & credits_full_i);

  assign struct_haz = ~fe_cmd_ready_i
    | (isd_mem_i & ~mmu_cmd_ready_i);

  assign chk_dispatch_v_o = ~(data_haz | ctrl_haz | struct_haz);
  assign idle_o           = ~any_v & sb_empty & ~drain;

  // Serialising ops hold issue until the backend is fully quiet.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= e_det_idle;
    end else begin
      unique case (state_r)
        e_det_idle: begin
          if (dispatch & (isd_serial_i | isd_fence_i)) begin
            state_r <= e_det_drain;
          end
        end
        e_det_drain: begin
          if (drain_done) begin
            state_r <= e_det_idle;
          end
        end
        default: state_r <= e_det_idle;
      endcase
    end
  end

  // Saturating stall-cycle counters, one per hazard class.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_cnt_r   <= '0;
      ctrl_cnt_r   <= '0;
      struct_cnt_r <= '0;
    end else begin
      if (isd_v_i && data_haz && (data_cnt_r != '1)) begin
        data_cnt_r <= data_cnt_r + cnt_one_lp;
      end
      if (isd_v_i && ctrl_haz && (ctrl_cnt_r != '1)) begin
        ctrl_cnt_r <= ctrl_cnt_r + cnt_one_lp;
      end
      if (isd_v_i && struct_haz
          && (struct_cnt_r != '1)) begin
        struct_cnt_r <= struct_cnt_r + cnt_one_lp;
      end
    end
  end

  assign data_stall_cnt_o   = data_cnt_r;
  assign ctrl_stall_cnt_o   = ctrl_cnt_r;
  assign struct_stall_cnt_o = struct_cnt_r;

endmodule

// File: tb/tb_bp_be_scoreboard_detector.sv
// Directed bench for the backend hazard detector.
// Narrow counters so saturation is reachable quickly.
module tb_bp_be_scoreboard_detector;

  localparam int CW = 5;

  logic          clk;
  logic          reset_i;
  logic          isd_v;
  logic [2:0]    src_v;
  logic [2:0]    src_fp;
  logic [14:0]   src_addr;
  logic          rd_v;
  logic          rd_fp;
  logic [4:0]    rd_addr;
  logic [2:0]    fwd;
  logic          is_long;
  logic          is_mem;
  logic          is_fence;
  logic          is_serial;
  logic          flush;
  logic          wb_v;
  logic          wb_fp;
  logic [4:0]    wb_addr;
  logic          credits_full;
  logic          credits_empty;
  logic          mmu_ready;
  logic          fe_ready;
  logic          chk_v;
  logic          idle;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] scnt;

  int tests;
  int fails;

  bp_be_scoreboard_detector #(
    .cnt_width_p(CW)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .isd_v_i           (isd_v),
    .isd_src_v_i       (src_v),
    .isd_src_fp_i      (src_fp),
    .isd_src_addr_i    (src_addr),
    .isd_rd_v_i        (rd_v),
    .isd_rd_fp_i       (rd_fp),
    .isd_rd_addr_i     (rd_addr),
    .isd_fwd_stage_i   (fwd),
    .isd_long_i        (is_long),
    .isd_mem_i         (is_mem),
    .isd_fence_i       (is_fence),
    .isd_serial_i      (is_serial),
    .flush_i           (flush),
    .late_wb_v_i       (wb_v),
    .late_wb_fp_i      (wb_fp),
    .late_wb_addr_i    (wb_addr),
    .credits_full_i    (credits_full),
    .credits_empty_i   (credits_empty),
    .mmu_cmd_ready_i   (mmu_ready),
    .fe_cmd_ready_i    (fe_ready),
    .chk_dispatch_v_o  (chk_v),
    .idle_o            (idle),
    .data_stall_cnt_o  (dcnt),
    .ctrl_stall_cnt_o  (ccnt),
    .struct_stall_cnt_o(scnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag,
                      input logic [CW-1:0] obs,
                      input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic quiet();
    isd_v         = 1'b0;
    src_v         = 3'b000;
    src_fp        = 3'b000;
    src_addr      = 15'd0;
    rd_v          = 1'b0;
    rd_fp         = 1'b0;
    rd_addr       = 5'd0;
    fwd           = 3'd0;
    is_long       = 1'b0;
    is_mem        = 1'b0;
    is_fence      = 1'b0;
    is_serial     = 1'b0;
    flush         = 1'b0;
    wb_v          = 1'b0;
    wb_fp         = 1'b0;
    wb_addr       = 5'd0;
    credits_full  = 1'b0;
    credits_empty = 1'b1;
    mmu_ready     = 1'b1;
    fe_ready      = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    #2;
    reset_i = 1'b1;
  endtask

  task automatic prod(input logic [4:0] a, input logic f,
                      input logic [2:0] fw);
    isd_v   = 1'b1;
    rd_v    = 1'b1;
    rd_fp   = f;
    rd_addr = a;
    fwd     = fw;
  endtask

  task automatic cons(input logic [4:0] a, input logic f);
    isd_v    = 1'b1;
    src_v    = 3'b001;
    src_fp   = {2'b00, f};
    src_addr = {10'd0, a};
    rd_v     = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_i = 1'b0;
    quiet();
    #2;
    chk1("rst_dispatch", chk_v, 1'b1);
    chk1("rst_idle", idle, 1'b1);
    chkc("rst_dcnt", dcnt, 5'd0);
    chkc("rst_ccnt", ccnt, 5'd0);
    chkc("rst_scnt", scnt, 5'd0);
    #10;
    reset_i = 1'b1;
    tick();

    // RAW against a producer forwardable from stage 3
    prod(5'd5, 1'b0, 3'd3);
    settle();
    chk1("raw_prod", chk_v, 1'b1);
    tick(); quiet(); cons(5'd5, 1'b0); settle();
    chk1("raw_c1", chk_v, 1'b0);
    tick(); settle();
    chk1("raw_c2", chk_v, 1'b0);
    tick(); settle();
    chk1("raw_c3", chk_v, 1'b1);
    chkc("raw_cnt", dcnt, 5'd2);
    tick(); quiet();

    // x0 exemption and register-file separation
    prod(5'd0, 1'b0, 3'd4);
    tick(); quiet(); cons(5'd0, 1'b0); settle();
    chk1("x0_src", chk_v, 1'b1);
    tick(); quiet(); prod(5'd3, 1'b1, 3'd4);
    tick(); quiet(); cons(5'd3, 1'b0); settle();
    chk1("file_sep", chk_v, 1'b1);
    tick(); quiet(); cons(5'd3, 1'b1); settle();
    chk1("fp_raw", chk_v, 1'b0);
    tick(); quiet();
    repeat (6) tick();
    chk1("idle_drained", idle, 1'b1);

    // Long-latency op tracked by the scoreboard
    do_reset();
    tick();
    prod(5'd7, 1'b0, 3'd0);
    is_long = 1'b1;
    settle();
    chk1("div_ok", chk_v, 1'b1);
    tick(); quiet(); cons(5'd7, 1'b0); settle();
    chk1("long_c1", chk_v, 1'b0);
    chk1("long_busy_idle", idle, 1'b0);
    tick(); quiet(); prod(5'd7, 1'b0, 3'd0); settle();
    chk1("waw", chk_v, 1'b0);
    for (int k = 3; k <= 19; k++) begin
      tick(); quiet(); cons(5'd7, 1'b0);
    end
    tick(); quiet(); cons(5'd7, 1'b0);
    wb_v    = 1'b1;
    wb_addr = 5'd7;
    settle();
    chk1("long_c20", chk_v, 1'b0);
    tick(); quiet(); cons(5'd7, 1'b0); settle();
    chk1("long_c21", chk_v, 1'b1);
    chkc("long_cnt", dcnt, 5'd20);
    tick(); quiet(); prod(5'd7, 1'b0, 3'd0);
    is_long = 1'b1;
    wb_v    = 1'b1;
    wb_addr = 5'd7;
    settle();
    chk1("set_clr_ok", chk_v, 1'b1);
    tick(); quiet(); cons(5'd7, 1'b0); settle();
    chk1("set_wins", chk_v, 1'b0);
    wb_v    = 1'b1;
    wb_addr = 5'd7;
    tick(); quiet(); cons(5'd7, 1'b0); settle();
    chk1("wb_clears", chk_v, 1'b1);
    tick(); quiet();

    // Serialising op drains pipe and waits for credits
    do_reset();
    tick();
    credits_empty = 1'b0;
    isd_v         = 1'b1;
    tick();
    tick(); quiet();
    credits_empty = 1'b0;
    isd_v         = 1'b1;
    is_serial     = 1'b1;
    settle();
    chk1("csr_ok", chk_v, 1'b1);
    tick(); quiet();
    credits_empty = 1'b0;
    isd_v         = 1'b1;
    settle();
    chk1("drain_c0", chk_v, 1'b0);
    chk1("drain_idle", idle, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk1("drain_flush", chk_v, 1'b0);
    tick();
    tick();
    tick();
    credits_empty = 1'b1;
    settle();
    chk1("drain_c6", chk_v, 1'b0);
    tick(); settle();
    chk1("drain_exit", chk_v, 1'b1);
    chkc("ctrl_cnt", ccnt, 5'd7);
    chkc("drain_dcnt", dcnt, 5'd0);
    tick(); quiet();

    // Flush removes pipe RAW but not scoreboard state
    do_reset();
    tick();
    prod(5'd12, 1'b0, 3'd0);
    is_long = 1'b1;
    tick(); quiet(); prod(5'd9, 1'b0, 3'd7);
    tick();
    tick();
    tick();
    tick(); quiet(); cons(5'd9, 1'b0); settle();
    chk1("flush_pre", chk_v, 1'b0);
    flush = 1'b1;
    tick(); quiet(); cons(5'd9, 1'b0); settle();
    chk1("flush_post", chk_v, 1'b1);
    tick(); quiet(); cons(5'd12, 1'b0); settle();
    chk1("flush_sb_kept", chk_v, 1'b0);
    wb_v    = 1'b1;
    wb_addr = 5'd12;
    tick(); quiet();
    repeat (5) tick();
    chk1("flush_idle", idle, 1'b1);

    // Control/struct causes, then async reset mid-drain
    do_reset();
    tick();
    credits_empty = 1'b0;
    isd_v         = 1'b1;
    is_fence      = 1'b1;
    settle();
    chk1("fence_credits", chk_v, 1'b0);
    tick(); quiet();
    isd_v        = 1'b1;
    is_mem       = 1'b1;
    credits_full = 1'b1;
    settle();
    chk1("mem_full", chk_v, 1'b0);
    tick(); quiet();
    isd_v     = 1'b1;
    is_mem    = 1'b1;
    mmu_ready = 1'b0;
    settle();
    chk1("mmu_busy", chk_v, 1'b0);
    tick(); quiet();
    credits_empty = 1'b0;
    isd_v         = 1'b1;
    is_serial     = 1'b1;
    settle();
    chk1("serial_ok", chk_v, 1'b1);
    tick(); quiet();
    credits_empty = 1'b0;
    isd_v         = 1'b1;
    tick();
    tick();
    tick();
    chkc("pre_rst_ccnt", ccnt, 5'd5);
    chkc("pre_rst_scnt", scnt, 5'd1);
    chk1("pre_rst_idle", idle, 1'b0);
    reset_i = 1'b0;
    #1;
    chk1("rst_mid_idle", idle, 1'b1);
    chkc("rst_mid_ccnt", ccnt, 5'd0);
    chkc("rst_mid_scnt", scnt, 5'd0);
    chk1("rst_mid_disp", chk_v, 1'b1);
    #1;
    reset_i = 1'b1;
    tick(); settle();
    chk1("post_rst_disp", chk_v, 1'b1);
    tick(); quiet();

    // Saturation of a stall counter
    do_reset();
    tick();
    fe_ready = 1'b0;
    isd_v    = 1'b1;
    settle();
    chk1("fe_stall", chk_v, 1'b0);
    repeat (31) tick();
    chkc("sat_31", scnt, 5'd31);
    repeat (9) tick();
    chkc("sat_hold", scnt, 5'd31);
    quiet();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
